// File: rtl/seven_seg_ctrl.sv
// seven_seg_ctrl: captures a bus value, converts it to hex or decimal glyphs
// and multiplexes them over DIGITS active-low seven-segment digits.
// Optional macro SEVEN_SEG_BLANK_EN blanks leading digits (digit[0] always shown).
module seven_seg_ctrl #(
    parameter int DATA_W      = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] bus,
    output logic [7:0]        segments,
    output logic [DIGITS-1:0] digit,
    output logic              busy
);
    localparam int NB = (DATA_W * 301) / 1000 + 1;
    localparam int NH = (DATA_W + 3) / 4;
    localparam int NV = (NB > NH) ? NB : NH;
    localparam int SW = 4 * (NV + DIGITS);
    localparam int CW = $clog2(DATA_W);
    localparam int IW = $clog2(DIGITS);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;
`ifdef SEVEN_SEG_BLANK_EN
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_LEAD  = SEG_BLANK;
`else
    localparam logic [7:0] SEG_LEAD  = SEG_ZERO;
`endif

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic                   pend_v_q;
    logic [1:0]             pend_mode_q;
    logic [DATA_W-1:0]      pend_bus_q;
    logic                   hex_q;
    logic                   neg_q;
    logic [DATA_W-1:0]      bin_q;
    logic [4*NB-1:0]        bcd_q;
    logic [CW-1:0]          cnt_q;
    logic [DIGITS-1:0][7:0] glyph_q;
    logic [PW-1:0]          presc_q;
    logic [IW-1:0]          idx_q;
    logic [DIGITS-1:0]      digit_q;
    logic [7:0]             seg_q;

    logic [1:0]             cap_mode;
    logic [DATA_W-1:0]      cap_bus;
    logic [DATA_W-1:0]      cap_mag;
    logic                   cap_hex;
    logic                   cap_neg;
    logic [4*NB-1:0]        bcd_d;
    logic [SW-1:0]          src;
    logic [DIGITS-1:0][7:0] glyph_d;
    logic [3:0]             dv;
    int                     msd_c;
    int                     need_c;
    logic                   tc;
    logic [IW-1:0]          idx_d;

    function automatic logic [7:0] seg_of(input logic [3:0] v);
        logic [7:0] s;
        unique case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Pick the live input over the pending entry; take magnitude for signed.
    always_comb begin
        cap_mode = enable ? mode : pend_mode_q;
        cap_bus  = enable ? bus : pend_bus_q;
        cap_hex  = (cap_mode == 2'b00) || (cap_mode == 2'b11);
        cap_neg  = (cap_mode == 2'b10) && cap_bus[DATA_W-1];
        cap_mag  = cap_neg ? -cap_bus : cap_bus;
    end

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    always_comb begin
        bcd_d = bcd_q;
        for (int i = 0; i < NB; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Build all digit glyphs from the finished work register.
    always_comb begin
        src     = hex_q ? SW'(bin_q) : SW'(bcd_q);
        msd_c   = 0;
        glyph_d = '0;
        dv      = 4'h0;
        for (int i = 0; i < NV; i++) begin
            if (src[4*i +: 4] != 4'h0) msd_c = i;
        end
        need_c = msd_c + 1 + (neg_q ? 1 : 0);
        for (int i = 0; i < DIGITS; i++) begin
            dv = src[4*i +: 4];
            if (need_c > DIGITS) begin
                glyph_d[i] = SEG_MINUS;
`ifdef SEVEN_SEG_BLANK_EN
            end else if (i <= msd_c) begin
                glyph_d[i] = seg_of(dv);
            end else if (neg_q && (i == msd_c + 1)) begin
                glyph_d[i] = SEG_MINUS;
            end else begin
                glyph_d[i] = SEG_BLANK;
`else
            end else if (neg_q && (i == DIGITS - 1)) begin
                glyph_d[i] = SEG_MINUS;
            end else begin
                glyph_d[i] = seg_of(dv);
`endif
            end
        end
    end

    // Prescaler terminal count and next active digit index.
    always_comb begin
        tc    = (presc_q == PW'(REFRESH_DIV - 1));
        idx_d = idx_q;
        if (tc) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Capture / convert / update controller with one-deep pending slot.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_mode_q <= 2'b00;
            pend_bus_q  <= '0;
            hex_q       <= 1'b1;
            neg_q       <= 1'b0;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
        end else begin
            if ((state_q != IDLE) && enable) begin
                pend_v_q    <= 1'b1;
                pend_mode_q <= mode;
                pend_bus_q  <= bus;
            end
            unique case (state_q)
                IDLE: begin
                    busy_q <= enable || pend_v_q;
                    if (enable || pend_v_q) begin
                        pend_v_q <= 1'b0;
                        hex_q    <= cap_hex;
                        neg_q    <= cap_neg;
                        bin_q    <= cap_mag;
                        bcd_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= cap_hex ? UPDATE : CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd_q, bin_q} <= {bcd_d, bin_q} << 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DATA_W - 1)) state_q <= UPDATE;
                end
                UPDATE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Glyph bank load and digit multiplexing with registered segments.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                glyph_q[i] <= (i == 0) ? SEG_ZERO : SEG_LEAD;
            end
            presc_q <= '0;
            idx_q   <= '0;
            digit_q <= DIGITS'(1);
            seg_q   <= SEG_ZERO;
        end else begin
            if (state_q == UPDATE) glyph_q <= glyph_d;
            if (tc) begin
                presc_q <= '0;
                digit_q <= {digit_q[DIGITS-2:0], digit_q[DIGITS-1]};
            end else begin
                presc_q <= presc_q + PW'(1);
            end
            idx_q <= idx_d;
            seg_q <= glyph_q[idx_d];
        end
    end

    assign segments = seg_q;
    assign digit    = digit_q;
    assign busy     = busy_q;

endmodule

// File: doc/seven_seg_ctrl.md
SEVEN_SEG_CTRL -- requirements
Module: seven_seg_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the width of the bus value displayed (4..16).
REQ-002 The block SHALL have parameter DIGITS, default 4, meaning the number of physical digits driven (2..8).
REQ-003 The block SHALL have parameter REFRESH_DIV, default 1000, meaning the cpu_clk cycles per digit-multiplex step (>=1).
REQ-004 The block SHALL have port cpu_clk  in  1  clock; all state on rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port enable  in  1  capture bus and mode on this cycle.
REQ-007 The block SHALL have port mode  in  2  display mode: 00 hex, 01 unsigned decimal, 10 signed decimal, 11 reserved (treated as hex).
REQ-008 The block SHALL have port bus  in  DATA_W  value to display.
REQ-009 The block SHALL have port segments  out  8  active-low; bit0..6 = A..G, bit7 = DOT.
REQ-010 The block SHALL have port digit  out  DIGITS  one-hot, active-high; digit[0] = least significant.
REQ-011 The block SHALL have port busy  out  1  high while a capture is being converted.

Function
REQ-012 FSM states SHALL be IDLE, CONVERT and UPDATE; in IDLE, enable SHALL capture bus/mode into a work register and go to CONVERT.
REQ-013 Hex mode SHALL spend 0 cycles in CONVERT; decimal modes SHALL spend exactly DATA_W cycles in CONVERT, doing one shift-add-3 (double-dabble) step per cycle.
REQ-014 Signed mode with the bus MSB set SHALL convert the two's-complement magnitude; the most negative value (e.g. 0x80 -> 128) SHALL convert correctly.
REQ-015 UPDATE SHALL last one cycle and load all DIGITS glyph registers at once, so hex results SHALL appear 2 edges after the capture edge and decimal results DATA_W+2 edges after it.
REQ-016 busy SHALL be high from the edge after capture through the UPDATE cycle inclusive.
REQ-017 Until UPDATE, the displayed glyphs SHALL hold the previous value, with no partial or flickering results.
REQ-018 Enable asserted while busy SHALL store bus/mode in a one-deep pending register, with the latest value winning; after UPDATE, a valid pending entry SHALL start CONVERT on the next edge and then be cleared.
REQ-019 Enable asserted in the same cycle as UPDATE SHALL be stored as pending.
REQ-020 Glyphs SHALL be: hex digits 0-9 and A b C d E F; minus = G only; blank = no segments; DOT SHALL always be off.
REQ-021 A negative value SHALL place a minus on the digit immediately above its most significant nonzero digit.
REQ-022 Overflow, meaning the result including any minus needs more than DIGITS digits, SHALL show minus on every digit.
REQ-023 The multiplex prescaler SHALL count 0..REFRESH_DIV-1 on cpu_clk; at terminal count, digit SHALL rotate left by one (digit[DIGITS-1] wraps to digit[0]).
REQ-024 segments SHALL be registered and SHALL always correspond to the currently active digit.

Reset
REQ-025 On rst, the block SHALL set state IDLE, busy 0, pending cleared, prescaler 0, digit = 1 (digit[0]) and the displayed value 0.
REQ-026 Immediately after reset, segments SHALL be 8'hC0 ("0" on digit[0]).
REQ-027 rst asserted mid-conversion SHALL abort the conversion and discard both work and pending values.

Configuration
REQ-028 With macro SEVEN_SEG_BLANK_EN defined, digits above the most significant nonzero digit (and above any minus) SHALL be blank (8'hFF), while digit[0] SHALL always be shown.
REQ-029 Without SEVEN_SEG_BLANK_EN, every digit SHALL show its value, with leading zeros shown as "0" and the minus placed on digit[DIGITS-1].

Verification (defaults, SEVEN_SEG_BLANK_EN defined unless stated)
REQ-030 mode=00, bus=0xA5, one enable -> busy high 2 cycles; digit[0] segments 8'h92 ("5"), digit[1] 8'h88 ("A"), digit[2..3] 8'hFF.
REQ-031 mode=01, bus=0xFF -> busy high 10 cycles; digits 0..2 show 8'h92, 8'h92, 8'hA4 ("255"); digit[3] blank.
REQ-032 mode=10, bus=0x80 -> digits 0..3 show 8'h80, 8'hA4, 8'hF9, 8'hBF ("-128").
REQ-033 Enable 0x01 then enable 0x02 and 0x03 while busy (mode=01) -> "1" is displayed, then "3"; 0x02 is never displayed.
REQ-034 DIGITS=2, mode=01, bus=200 -> both digits 8'hBF (overflow); rst mid-conversion -> busy 0 next edge and segments 8'hC0.
REQ-035 REFRESH_DIV=4 -> digit sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles.
